// File: rtl/sync_counter_8.sv
// sync_counter_8: loadable up-counter wrapping after MAX_VAL, load clamped to MAX_VAL.
// Define SYNC_COUNTER_8_TC_EN to add the combinational terminal-count output tc.
module sync_counter_8 #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = 2**WIDTH-1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_out
`ifdef SYNC_COUNTER_8_TC_EN
  ,
  output logic             tc
`endif
);
  localparam logic [WIDTH-1:0] max_v = WIDTH'(MAX_VAL);
  logic             at_max;
  logic [WIDTH-1:0] nxt;
  always_comb begin
    at_max = count_out == max_v;
    nxt    = load   ? (load_val > max_v ? max_v : load_val) :
             enable ? (at_max ? '0 : count_out + WIDTH'(1)) :
                      count_out;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) count_out <= '0;
    else        count_out <= nxt;
`ifdef SYNC_COUNTER_8_TC_EN
  assign tc = at_max & enable & ~load & reset;
`endif
endmodule

// File: tb/tb_sync_counter_8.sv
// tb_sync_counter_8: directed checks of a default instance and a MAX_VAL=9 instance.
module tb_sync_counter_8;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0, load = 1'b0;
  logic [7:0] load_val = '0;
  logic       en9 = 1'b0, ld9 = 1'b0;
  logic [7:0] lv9 = '0;
  logic [7:0] count_out, cnt9;
`ifdef SYNC_COUNTER_8_TC_EN
  logic       tc, tc9;
`endif
  int n_vec = 0, n_err = 0;

  always #5 clock = ~clock;

  sync_counter_8 u_dut (
    .clock(clock), .reset(reset), .enable(enable), .load(load),
    .load_val(load_val), .count_out(count_out)
`ifdef SYNC_COUNTER_8_TC_EN
    , .tc(tc)
`endif
  );

  sync_counter_8 #(.WIDTH(8), .MAX_VAL(9)) u_nine (
    .clock(clock), .reset(reset), .enable(en9), .load(ld9),
    .load_val(lv9), .count_out(cnt9)
`ifdef SYNC_COUNTER_8_TC_EN
    , .tc(tc9)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clock);
  endtask

  initial begin
    // reset falls before the first clock edge: output must clear at once
    #2 reset = 1'b0;
    #1 check("rst_imm", count_out, 8'h00);
    check("rst_imm9", cnt9, 8'h00);
    #9 reset = 1'b1;
    tick;
    check("rst_hold0", count_out, 8'h00);
    tick;
    check("rst_hold1", count_out, 8'h00);
    enable = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick;
      check("count", count_out, i);
    end
    enable = 1'b0;
    tick;
    check("hold20a", count_out, 8'h14);
    tick;
    check("hold20b", count_out, 8'h14);
    check("idle9", cnt9, 8'h00);
    // wrap through FF
    load_val = 8'hFE;
    load = 1'b1;
    tick;
    check("wrap_fe", count_out, 8'hFE);
    load = 1'b0;
    enable = 1'b1;
    #1;
`ifdef SYNC_COUNTER_8_TC_EN
    check("tc_fe", tc, 1'b0);
`endif
    tick;
    check("wrap_ff", count_out, 8'hFF);
`ifdef SYNC_COUNTER_8_TC_EN
    check("tc_ff", tc, 1'b1);
`endif
    tick;
    check("wrap_00", count_out, 8'h00);
`ifdef SYNC_COUNTER_8_TC_EN
    check("tc_00", tc, 1'b0);
`endif
    tick;
    check("wrap_01", count_out, 8'h01);
`ifdef SYNC_COUNTER_8_TC_EN
    check("tc_01", tc, 1'b0);
`endif
    // load beats enable on the same edge
    load_val = 8'h55;
    load = 1'b1;
    tick;
    check("ld_prio", count_out, 8'h55);
    load_val = 8'h30;
    tick;
    check("ld_30", count_out, 8'h30);
    load = 1'b0;
    #2 reset = 1'b0;
    #1 check("rst_mid", count_out, 8'h00);
`ifdef SYNC_COUNTER_8_TC_EN
    check("tc_rst", tc, 1'b0);
`endif
    load = 1'b1;
    load_val = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1 check("rst_low", count_out, 8'h00);
    end
    tick;
    reset = 1'b1;
    load = 1'b0;
    tick;
    check("post_rst", count_out, 8'h01);
    enable = 1'b0;
    // MAX_VAL = 9 instance
    en9 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick;
      check("cnt9", cnt9, i % 10);
`ifdef SYNC_COUNTER_8_TC_EN
      check("tc9", tc9, i == 9);
`endif
    end
    en9 = 1'b0;
    ld9 = 1'b1;
    lv9 = 8'h0C;
    tick;
    check("clamp9", cnt9, 8'h09);
    ld9 = 1'b0;
    tick;
    check("clamp9_hold", cnt9, 8'h09);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sync_counter_8.md
SYNC_COUNTER_8 -- requirements
Module: sync_counter_8

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, counter width in bits.
REQ-002 The block SHALL expose parameter MAX_VAL, default 2**WIDTH-1, last count value before wrap; legal range 1..2**WIDTH-1.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clock and reset.
REQ-004 Port: clock, input, 1, rising-edge clock for all state.
REQ-005 Port: reset, input, 1, asynchronous active-low reset.
REQ-006 Port: enable, input, 1, count-advance qualifier, sampled on rising clock.
REQ-007 Port: load, input, 1, synchronous load strobe.
REQ-008 Port: load_val, input, WIDTH, value written on load.
REQ-009 Port: count_out, output, WIDTH, registered counter value.

Function
REQ-010 count_out SHALL update only on the rising edge of clock, except on reset assertion.
REQ-011 Priority at each rising edge SHALL be: reset low > load > enable > hold.
REQ-012 load=1 SHALL set count_out to load_val on that edge, regardless of enable.
REQ-013 load_val greater than MAX_VAL SHALL be clamped: count_out loads MAX_VAL.
REQ-014 load=0 with enable=1 SHALL set count_out to count_out+1 on that edge (latency one cycle).
REQ-015 enable=1 with count_out==MAX_VAL SHALL wrap count_out to 0 on that edge.
REQ-016 load=0 with enable=0 SHALL hold count_out unchanged.
REQ-017 Arithmetic SHALL be unsigned modulo MAX_VAL+1; no intermediate value wider than WIDTH+1 bits.
REQ-018 Inputs enable, load, load_val SHALL have no effect while reset is low.

Reset
REQ-019 Falling reset SHALL force count_out to 0 immediately, without waiting for a clock edge.
REQ-020 count_out SHALL remain 0 while reset is low, including across clock edges with enable=1 or load=1.
REQ-021 The first rising edge with reset high SHALL apply the normal priority rules from count_out=0.
REQ-022 Reset asserted mid-count SHALL discard the current count; no state survives reset.

Configuration
REQ-023 Macro SYNC_COUNTER_8_TC_EN, when defined, SHALL add output port tc (1 bit), placed after count_out.
REQ-024 With SYNC_COUNTER_8_TC_EN defined, tc SHALL be combinational: 1 when count_out==MAX_VAL and enable==1 and load==0 and reset==1, else 0.
REQ-025 With SYNC_COUNTER_8_TC_EN undefined, port tc and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-026 Bench SHALL check reset: reset=0 for 10 ns with enable=0 -> count_out=0 immediately at reset fall; hold at 0 after release with enable=0.
REQ-027 Bench SHALL check counting: from 0, enable=1 for 20 rising edges (clock period 10 ns) then enable=0 -> count_out=20 (8'h14), held constant afterwards.
REQ-028 Bench SHALL check wrap: load_val=8'hFE, load=1 for one edge, then enable=1 -> count_out sequence FE, FF, 00, 01; with SYNC_COUNTER_8_TC_EN, tc=1 only while count_out=FF.
REQ-029 Bench SHALL check load priority: enable=1, load=1, load_val=8'h55 on the same edge -> count_out=8'h55, not an increment.
REQ-030 Bench SHALL check async reset mid-count: count_out=8'h30, enable=1, reset falls between edges -> count_out=0 before the next edge; stays 0 over 3 edges while reset low.
REQ-031 Bench SHALL check MAX_VAL=9 instance: enable=1 from 0 -> 0..9 then 0; load_val=8'h0C -> count_out=9.
